arctan_sched: RTL and testbench

ARCTAN_SCHED -- requirements
Module: arctan_sched

---
 rtl/arctan_sched_if.sv | 48 ++++
 rtl/arctan_sched.sv | 115 +++++++++++
 tb/tb_arctan_sched.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arctan_sched_if.sv
// arctan_sched_if: request, shared-arctan-unit and result signals of arctan_sched.
// The master side drives the requests, the arctan result and out_ready; the slave side is the scheduler.
interface arctan_sched_if;
    logic               req0_valid;
    logic signed [31:0] req0_x;
    logic signed [31:0] req0_y;
    logic               req0_ready;

    logic               req1_valid;
    logic signed [31:0] req1_x;
    logic signed [31:0] req1_y;
    logic               req1_ready;

    logic signed [31:0] at_x;
    logic signed [31:0] at_y;
    logic signed [31:0] at_theta;

    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_theta;
    logic               out_id;

    logic               busy;

    modport master (
        output req0_valid, req0_x, req0_y,
        input  req0_ready,
        output req1_valid, req1_x, req1_y,
        input  req1_ready,
        input  at_x, at_y,
        output at_theta,
        input  out_valid, out_theta, out_id,
        output out_ready,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_x, req0_y,
        output req0_ready,
        input  req1_valid, req1_x, req1_y,
        output req1_ready,
        output at_x, at_y,
        input  at_theta,
        output out_valid, out_theta, out_id,
        input  out_ready,
        output busy
    );
endinterface

// File: rtl/arctan_sched.sv
// arctan_sched: shares one combinational arctan unit between two requesters.
// Flow per request: IDLE (accept) -> ISSUE (one settle cycle) -> HOLD (until out_ready).
// Contention is round-robin on a last-grant pointer; defining ARCTAN_SCHED_FIXED_PRIO_EN
// makes requester 0 always win instead (the pointer is still updated).
module arctan_sched (
    input logic          clk,
    input logic          rst,
    arctan_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e             state_q;
    logic               ptr_q;        // id of the last granted requester
    logic signed [31:0] op_x_q;
    logic signed [31:0] op_y_q;
    logic               op_id_q;
    logic               out_valid_q;
    logic signed [31:0] out_theta_q;
    logic               out_id_q;

    logic               grant0;
    logic               grant1;
    logic               accept;
    logic               accept_id;
    logic               zero_ops;

    // Arbitration between the two requesters; only meaningful while IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ARCTAN_SCHED_FIXED_PRIO_EN
            grant0 = 1'b1;
`else
            // Grant whichever requester the pointer does not name.
            if (ptr_q) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
`endif
        end else if (bus.req0_valid) begin
            grant0 = 1'b1;
        end else if (bus.req1_valid) begin
            grant1 = 1'b1;
        end
    end

    assign bus.req0_ready = (state_q == IDLE) && grant0;
    assign bus.req1_ready = (state_q == IDLE) && grant1;

    // Grants already imply valid, so a high ready is an acceptance at the next edge.
    assign accept    = bus.req0_ready || bus.req1_ready;
    assign accept_id = bus.req1_ready;

    // A (0,0) operand pair has no defined angle; the result is forced to 0.
    assign zero_ops  = (op_x_q == 32'sd0) && (op_y_q == 32'sd0);

    assign bus.at_x      = op_x_q;
    assign bus.at_y      = op_y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_theta = out_theta_q;
    assign bus.out_id    = out_id_q;
    assign bus.busy      = (state_q != IDLE);

    // Scheduler FSM with its operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b1;
            op_x_q      <= '0;
            op_y_q      <= '0;
            op_id_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_theta_q <= '0;
            out_id_q    <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_x_q  <= accept_id ? bus.req1_x : bus.req0_x;
                        op_y_q  <= accept_id ? bus.req1_y : bus.req0_y;
                        op_id_q <= accept_id;
                        ptr_q   <= accept_id;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    out_theta_q <= zero_ops ? 32'sd0 : bus.at_theta;
                    out_id_q    <= op_id_q;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arctan_sched.sv
// tb_arctan_sched: directed scoreboard bench for arctan_sched.
// Stimulus pushes expected (id, theta) pairs; a negedge monitor pops them on every consumed result.
module tb_arctan_sched;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    arctan_sched_if bus ();

    arctan_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] theta;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [31:0] theta);
        exp_t e;
        e.id    = id;
        e.theta = theta;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 30) begin
            tick();
            n++;
        end
        if (bus.busy) begin
            checks++;
            failures++;
            $display("FAIL %s: got busy after %0d cycles, expected idle", name, n);
        end
    endtask

    // Monitor: every result consumed by the output handshake is checked against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got id=%0d theta=%0h, expected no result", bus.out_id, bus.out_theta);
            end else begin
                e = sb_q.pop_front();
                check("sb_id", 32'(bus.out_id), 32'(e.id));
                check("sb_theta", bus.out_theta, e.theta);
            end
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int n;
        logic [1:0] exp_ids [4];

        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_x     = '0;
        bus.req0_y     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_x     = '0;
        bus.req1_y     = '0;
        bus.at_theta   = '0;
        bus.out_ready  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_theta", bus.out_theta, 32'd0);
        check("rst_out_id", 32'(bus.out_id), 32'd0);
        check("rst_at_x", bus.at_x, 32'd0);
        check("rst_at_y", bus.at_y, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();

        // Single request on req0, result held two edges after accept (counting the accept edge)
        bus.at_theta   = 32'd1234;
        bus.req0_valid = 1'b1;
        bus.req0_x     = 32'd100;
        bus.req0_y     = 32'd100;
        #1;
        check("single_ready0", 32'(bus.req0_ready), 32'd1);
        check("single_ready1", 32'(bus.req1_ready), 32'd0);
        push(1'b0, 32'd1234);
        tick();
        bus.req0_valid = 1'b0;
        check("single_issue_busy", 32'(bus.busy), 32'd1);
        check("single_issue_valid", 32'(bus.out_valid), 32'd0);
        check("single_at_x", bus.at_x, 32'd100);
        check("single_at_y", bus.at_y, 32'd100);
        tick();
        check("single_latency_valid", 32'(bus.out_valid), 32'd1);
        check("single_theta", bus.out_theta, 32'd1234);
        tick();
        check("single_done_valid", 32'(bus.out_valid), 32'd0);
        check("single_done_busy", 32'(bus.busy), 32'd0);

        // Zero operands on req1 force theta to 0
        bus.at_theta   = 32'd77;
        bus.req1_valid = 1'b1;
        bus.req1_x     = 32'd0;
        bus.req1_y     = 32'd0;
        #1;
        check("zero_ready1", 32'(bus.req1_ready), 32'd1);
        push(1'b1, 32'd0);
        tick();
        bus.req1_valid = 1'b0;
        wait_idle("zero_idle");

        // Boundary operands visible on the arctan unit during ISSUE
        bus.at_theta   = 32'h0000_1111;
        bus.req0_valid = 1'b1;
        bus.req0_x     = 32'h8000_0000;
        bus.req0_y     = 32'h7FFF_FFFF;
        push(1'b0, 32'h0000_1111);
        tick();
        bus.req0_valid = 1'b0;
        check("bound_at_x", bus.at_x, 32'h8000_0000);
        check("bound_at_y", bus.at_y, 32'h7FFF_FFFF);
        wait_idle("bound_idle");

        // Back-pressure: result held stable, pending req0 not accepted, then served
        bus.out_ready  = 1'b0;
        bus.at_theta   = 32'd999;
        bus.req1_valid = 1'b1;
        bus.req1_x     = 32'd5;
        bus.req1_y     = 32'd6;
        push(1'b1, 32'd999);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        bus.req0_valid = 1'b1;
        bus.req0_x     = 32'd3;
        bus.req0_y     = 32'd4;
        bus.at_theta   = 32'd1;
        push(1'b0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_theta", bus.out_theta, 32'd999);
            check("bp_id", 32'(bus.out_id), 32'd1);
            check("bp_ready0", 32'(bus.req0_ready), 32'd0);
            check("bp_ready1", 32'(bus.req1_ready), 32'd0);
            check("bp_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_pending_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        wait_idle("bp_idle");

        // Reset pulse during ISSUE discards the transaction
        bus.at_theta   = 32'd5;
        bus.req1_valid = 1'b1;
        bus.req1_x     = 32'd9;
        bus.req1_y     = 32'd9;
        tick();
        bus.req1_valid = 1'b0;
        check("mid_issue_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_at_x", bus.at_x, 32'd0);
        check("mid_rst_at_y", bus.at_y, 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mid_no_pulse", 32'(bus.out_valid), 32'd0);
            tick();
        end

        // Contention right after reset: round-robin 0,1,0,1 (fixed priority 0,0,0,0)
`ifdef ARCTAN_SCHED_FIXED_PRIO_EN
        exp_ids = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_ids = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        bus.at_theta = 32'd42;
        for (int i = 0; i < 4; i++) push(exp_ids[i][0], 32'd42);
        bus.req0_valid = 1'b1;
        bus.req0_x     = 32'd1;
        bus.req0_y     = 32'd2;
        bus.req1_valid = 1'b1;
        bus.req1_x     = 32'd3;
        bus.req1_y     = 32'd4;
        acc = 0;
        n   = 0;
        while (acc < 4 && n < 40) begin
            #1;
            check("cont_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.req0_ready || bus.req1_ready) begin
                check("cont_grant", 32'(bus.req1_ready), 32'(exp_ids[acc][0]));
                acc++;
            end
            tick();
            n++;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("cont_accepts", acc, 32'd4);
        wait_idle("cont_idle");

        // Every expected result must have been consumed
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
